can_opb_bridge: RTL and testbench
=================================

Name: can_opb_bridge

Overview:
OPB slave front-end that sits directly upstream of the four-channel CAN interface block.
- Decodes OPB transfers into per-channel single-cycle RE/WE strobes, a 16-bit register address and write data.
- Captures the addressed channel's read data after a fixed latency, then returns it with a one-cycle transfer acknowledge.
- Gives OPB masters a clean, wait-stated path into the CAN controllers.

Parameters:
ADDR_BASE, 6'h01, value OPB_ABUS[23:18] must match for the bridge to respond
RD_LAT, 2, cycles from RE strobe to valid CANx_DO; legal range 1..7
CH_EN, 4'b1111, per-channel enable mask; bit n-1 enables CANn

Ports:
OPB_CLK  in  1  bridge clock, shared with CAN block
OPB_RST  in  1  asynchronous reset, active-high
OPB_SEL  in  1  master select, held high until ack
OPB_RNW  in  1  1 = read, 0 = write
OPB_ABUS  in  24  [23:18] base match, [17:16] channel (00 = CAN1 .. 11 = CAN4), [15:0] register address
OPB_DBUS_IN  in  32  write data
OPB_DBUS_OUT  out  32  read data, nonzero only in the ACK cycle (wired-OR bus)
OPB_XFERACK  out  1  one-cycle transfer acknowledge
OPB_ERRACK  out  1  one-cycle error acknowledge
CAN_ADDR  out  16  latched register address to all channels
CAN_DI  out  32  latched write data to all channels
CAN1_DO..CAN4_DO  in  32 each  channel read data
CAN1_RE..CAN4_RE  out  1 each  read strobes
CAN1_WE..CAN4_WE  out  1 each  write strobes

Behaviour:
- Reset (async, OPB_RST=1):
  - State = IDLE.
  - All strobes, XFERACK, ERRACK, OPB_DBUS_OUT, CAN_ADDR and CAN_DI = 0.
- Hit condition: OPB_SEL=1 and OPB_ABUS[23:18]==ADDR_BASE. Misses are ignored (no ack, no strobe).
- FSM states: IDLE, STROBE, WAIT, ACK, ERR, DONE.
- IDLE:
  - On hit, latch ABUS[15:0] into CAN_ADDR, channel into ch, OPB_RNW into rnw, DBUS_IN into CAN_DI.
  - If CH_EN[ch]=0, go to ERR; otherwise go to STROBE.
- STROBE:
  - Exactly one of the 8 strobes is high for exactly one cycle: CANn_RE if rnw, else CANn_WE, where n = ch+1.
  - Next state: write goes to ACK; read loads cnt=RD_LAT-1 and goes to WAIT.
- WAIT:
  - If cnt==0, capture CANn_DO into a data register and go to ACK; otherwise decrement cnt.
  - Capture edge is RD_LAT cycles after the end of the RE cycle.
- ACK:
  - OPB_XFERACK=1 for one cycle.
  - OPB_DBUS_OUT = captured data on reads, 0 on writes.
  - Next state: DONE.
- ERR: OPB_ERRACK=1 for one cycle, no strobe issued; next state DONE.
- DONE: OPB_DBUS_OUT=0; stay until OPB_SEL=0, then IDLE. This prevents re-triggering on a held select.
- Latency from the hit cycle in IDLE to the ack cycle:
  - write: ack in cycle 3;
  - read: ack in cycle 3+RD_LAT.
- Abort: OPB_SEL falling during STROBE or WAIT returns to IDLE on the next edge with no ack. A strobe already issued is not retracted. Captured data is discarded.
- CAN_ADDR and CAN_DI hold their last latched value between transfers. They change only on IDLE hits.
- XFERACK and ERRACK are never high together. At most one strobe is high in any cycle.
- Reset asserted mid-transfer forces every output to 0 immediately.

Test Plan:
1. Write: SEL=1, RNW=0, ABUS=24'h06_1234 (base 01, ch 2 = CAN3), DBUS_IN=32'hDEADBEEF.
   -> CAN_ADDR=16'h1234, CAN_DI=32'hDEADBEEF, CAN3_WE high exactly 1 cycle, XFERACK 1 cycle in cycle 3, no other strobe.
2. Read, RD_LAT=2: ABUS=24'h04_0010 (CAN1), CAN1_DO=32'hA5A5_0001 valid 2 cycles after RE.
   -> CAN1_RE 1 cycle, XFERACK in cycle 5 with DBUS_OUT=32'hA5A50001; DBUS_OUT=0 in every other cycle.
3. CH_EN=4'b0111, access to channel 3 (ABUS=24'h07_0000).
   -> ERRACK 1 cycle, no CAN4_RE/CAN4_WE, XFERACK stays 0.
4. ABUS[23:18]=6'h02 with SEL=1 for 20 cycles -> no strobe, no ack, state stays IDLE.
5. Hold SEL=1 for 10 cycles after ACK -> exactly one strobe and one ack; the next transfer is accepted only after SEL drops for ≥1 cycle.
6. Read aborted by SEL=0 in WAIT, or OPB_RST pulsed in WAIT -> no ack, immediate return of all outputs to 0 on reset, next transfer completes normally.

Source files
------------

// File: rtl/can_opb_bridge.sv
// OPB slave front-end for the four-channel CAN interface block.
// It decodes one OPB transfer into a single-cycle read or write strobe for
// one channel. Read data is captured a fixed number of cycles after the read
// strobe. Every transfer finishes with a one-cycle transfer ack or error ack.
module can_opb_bridge #(
    parameter logic [5:0]  ADDR_BASE = 6'h01,
    // Cycles from the read strobe to valid CANx_DO. The legal range is 1..7,
    // which fits in the 3-bit wait counter.
    parameter int unsigned RD_LAT    = 2,
    parameter logic [3:0]  CH_EN     = 4'b1111
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        OPB_SEL,
    input  logic        OPB_RNW,
    input  logic [23:0] OPB_ABUS,
    input  logic [31:0] OPB_DBUS_IN,
    output logic [31:0] OPB_DBUS_OUT,
    output logic        OPB_XFERACK,
    output logic        OPB_ERRACK,
    output logic [15:0] CAN_ADDR,
    output logic [31:0] CAN_DI,
    input  logic [31:0] CAN1_DO,
    input  logic [31:0] CAN2_DO,
    input  logic [31:0] CAN3_DO,
    input  logic [31:0] CAN4_DO,
    output logic        CAN1_RE,
    output logic        CAN2_RE,
    output logic        CAN3_RE,
    output logic        CAN4_RE,
    output logic        CAN1_WE,
    output logic        CAN2_WE,
    output logic        CAN3_WE,
    output logic        CAN4_WE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STROBE = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ACK    = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic        rnw_q, rnw_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] di_q, di_d;

    logic        hit;
    logic [31:0] do_sel;
    logic [3:0]  re_vec;
    logic [3:0]  we_vec;

    assign hit = OPB_SEL && (OPB_ABUS[23:18] == ADDR_BASE);

    // Select the read data of the latched channel
    always_comb begin
        case (ch_q)
            2'd0:    do_sel = CAN1_DO;
            2'd1:    do_sel = CAN2_DO;
            2'd2:    do_sel = CAN3_DO;
            default: do_sel = CAN4_DO;
        endcase
    end

    // Transfer sequencing: decode, strobe, wait for read data, then ack
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rnw_d   = rnw_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        di_d    = di_q;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    addr_d  = OPB_ABUS[15:0];
                    ch_d    = OPB_ABUS[17:16];
                    rnw_d   = OPB_RNW;
                    di_d    = OPB_DBUS_IN;
                    rdata_d = 32'd0;
                    state_d = CH_EN[OPB_ABUS[17:16]] ? S_STROBE : S_ERR;
                end
            end
            S_STROBE: begin
                // A dropped select aborts the transfer. The strobe has
                // already been issued and cannot be taken back.
                if (!OPB_SEL) begin
                    state_d = S_IDLE;
                end else if (rnw_q) begin
                    cnt_d   = 3'(RD_LAT - 1);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_WAIT: begin
                // An abort takes priority over the capture, so a late abort
                // still produces no ack.
                if (!OPB_SEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 3'd0) begin
                    rdata_d = do_sel;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK:   state_d = S_DONE;
            S_ERR:   state_d = S_DONE;
            S_DONE: begin
                // Hold here while select stays high, so a held select cannot
                // start a second transfer.
                if (!OPB_SEL) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched transfer fields, cleared by the asynchronous reset
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q <= S_IDLE;
            ch_q    <= 2'd0;
            rnw_q   <= 1'b0;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
            addr_q  <= 16'd0;
            di_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rnw_q   <= rnw_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
        end
    end

    // Per-channel strobes are decoded from the registered state, so the
    // reset drives them low at once
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
            assign re_vec[gi] = (state_q == S_STROBE) &&  rnw_q && (ch_q == 2'(gi));
            assign we_vec[gi] = (state_q == S_STROBE) && !rnw_q && (ch_q == 2'(gi));
        end
    endgenerate

    assign CAN1_RE = re_vec[0];
    assign CAN2_RE = re_vec[1];
    assign CAN3_RE = re_vec[2];
    assign CAN4_RE = re_vec[3];
    assign CAN1_WE = we_vec[0];
    assign CAN2_WE = we_vec[1];
    assign CAN3_WE = we_vec[2];
    assign CAN4_WE = we_vec[3];

    assign OPB_XFERACK  = (state_q == S_ACK);
    assign OPB_ERRACK   = (state_q == S_ERR);
    // The data bus is wired-OR, so it must be zero outside the read ack cycle
    assign OPB_DBUS_OUT = (state_q == S_ACK && rnw_q) ? rdata_q : 32'd0;
    assign CAN_ADDR     = addr_q;
    assign CAN_DI       = di_q;

endmodule

// File: tb/tb_can_opb_bridge.sv
// Testbench for can_opb_bridge. A transaction-level model schedules, per
// cycle, the strobes, acks, bus data and latched address/data the bridge
// must show. A CAN-side model returns address-derived data RD_LAT cycles
// after a read strobe and returns junk at every other time.
module tb_can_opb_bridge;

    localparam logic [5:0] BASE   = 6'h01;
    localparam int         RD_LAT = 2;
    localparam logic [3:0] CH_EN  = 4'b0111;
    localparam int         MAXC   = 16384;

    logic        OPB_CLK = 1'b0;
    logic        OPB_RST = 1'b1;
    logic        OPB_SEL = 1'b0;
    logic        OPB_RNW = 1'b0;
    logic [23:0] OPB_ABUS = 24'd0;
    logic [31:0] OPB_DBUS_IN = 32'd0;
    logic [31:0] OPB_DBUS_OUT;
    logic        OPB_XFERACK, OPB_ERRACK;
    logic [15:0] CAN_ADDR;
    logic [31:0] CAN_DI;
    logic [31:0] CAN1_DO, CAN2_DO, CAN3_DO, CAN4_DO;
    logic        CAN1_RE, CAN2_RE, CAN3_RE, CAN4_RE;
    logic        CAN1_WE, CAN2_WE, CAN3_WE, CAN4_WE;

    can_opb_bridge #(.ADDR_BASE(BASE), .RD_LAT(RD_LAT), .CH_EN(CH_EN)) dut (
        .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .OPB_SEL(OPB_SEL), .OPB_RNW(OPB_RNW),
        .OPB_ABUS(OPB_ABUS), .OPB_DBUS_IN(OPB_DBUS_IN), .OPB_DBUS_OUT(OPB_DBUS_OUT),
        .OPB_XFERACK(OPB_XFERACK), .OPB_ERRACK(OPB_ERRACK),
        .CAN_ADDR(CAN_ADDR), .CAN_DI(CAN_DI),
        .CAN1_DO(CAN1_DO), .CAN2_DO(CAN2_DO), .CAN3_DO(CAN3_DO), .CAN4_DO(CAN4_DO),
        .CAN1_RE(CAN1_RE), .CAN2_RE(CAN2_RE), .CAN3_RE(CAN3_RE), .CAN4_RE(CAN4_RE),
        .CAN1_WE(CAN1_WE), .CAN2_WE(CAN2_WE), .CAN3_WE(CAN3_WE), .CAN4_WE(CAN4_WE)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    int cyc = 0;
    always @(posedge OPB_CLK) cyc <= cyc + 1;

    // Register contents that the CAN block returns for (channel, address)
    function automatic logic [31:0] regval(input int ch, input logic [15:0] a);
        return {a ^ 16'hA5A5, a + 16'(ch)};
    endfunction

    // CAN-side model: data is valid exactly RD_LAT cycles after the RE cycle
    logic [RD_LAT-1:0] rep [4];
    logic [31:0]       junk;
    logic [3:0]        re_all, we_all;
    assign re_all = {CAN4_RE, CAN3_RE, CAN2_RE, CAN1_RE};
    assign we_all = {CAN4_WE, CAN3_WE, CAN2_WE, CAN1_WE};
    initial begin
        for (int n = 0; n < 4; n++) rep[n] = '0;
        junk = 32'h1357_9BDF;
    end
    always @(posedge OPB_CLK) begin
        for (int n = 0; n < 4; n++) rep[n] <= (rep[n] << 1) | RD_LAT'(re_all[n]);
        junk <= $urandom;
    end
    always_comb begin
        CAN1_DO = rep[0][RD_LAT-1] ? regval(0, CAN_ADDR) : junk;
        CAN2_DO = rep[1][RD_LAT-1] ? regval(1, CAN_ADDR) : ~junk;
        CAN3_DO = rep[2][RD_LAT-1] ? regval(2, CAN_ADDR) : junk ^ 32'h0F0F_0F0F;
        CAN4_DO = rep[3][RD_LAT-1] ? regval(3, CAN_ADDR) : junk ^ 32'hF0F0_F0F0;
    end

    // Per-cycle expectation timeline filled by the driver
    logic [7:0]  e_strb [MAXC];
    logic        e_x    [MAXC];
    logic        e_e    [MAXC];
    logic [31:0] e_db   [MAXC];
    logic        e_ld   [MAXC];
    logic [15:0] e_ad   [MAXC];
    logic [31:0] e_di   [MAXC];

    int total = 0;
    int bad   = 0;
    int obs_x_cyc = -1, obs_e_cyc = -1, obs_s_cyc = -1;
    logic [31:0] obs_db = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Compare process: every cycle, just after the active edge
    initial begin
        logic [15:0] m_ad;
        logic [31:0] m_di;
        logic [7:0]  es;
        logic        ex, ee;
        logic [31:0] ed;
        int          c;
        m_ad = 16'd0;
        m_di = 32'd0;
        forever begin
            @(posedge OPB_CLK);
            #1;
            c = cyc;
            if (c < MAXC) begin
                if (OPB_RST) begin
                    m_ad = 16'd0; m_di = 32'd0;
                    es = 8'd0; ex = 1'b0; ee = 1'b0; ed = 32'd0;
                end else begin
                    if (e_ld[c]) begin m_ad = e_ad[c]; m_di = e_di[c]; end
                    es = e_strb[c]; ex = e_x[c]; ee = e_e[c]; ed = e_db[c];
                end
                chk("strobes", {24'd0, we_all, re_all}, {24'd0, es});
                chk("xferack", {31'd0, OPB_XFERACK}, {31'd0, ex});
                chk("errack", {31'd0, OPB_ERRACK}, {31'd0, ee});
                chk("dbus_out", OPB_DBUS_OUT, ed);
                chk("can_addr", {16'd0, CAN_ADDR}, {16'd0, m_ad});
                chk("can_di", CAN_DI, m_di);
                if (OPB_XFERACK) begin obs_x_cyc = c; obs_db = OPB_DBUS_OUT; end
                if (OPB_ERRACK) obs_e_cyc = c;
                if ({we_all, re_all} != 8'd0) obs_s_cyc = c;
            end
        end
    end

    task automatic drive_miss(input logic [5:0] fixed_base, input bit use_fixed);
        logic [5:0] b;
        @(negedge OPB_CLK);
        b = use_fixed ? fixed_base : 6'($urandom);
        if (b == BASE) b = b ^ 6'h3;
        OPB_SEL     = use_fixed ? 1'b1 : 1'($urandom_range(0, 1));
        OPB_RNW     = 1'($urandom_range(0, 1));
        OPB_ABUS    = {b, 18'($urandom)};
        OPB_DBUS_IN = $urandom;
    endtask

    // One OPB transfer starting in IDLE. h = extra cycles with select held
    // after the ack, ab = abort point (-1 = none), g = idle gap of misses.
    task automatic xfer(input logic rnw, input int ch, input logic [15:0] ad,
                        input logic [31:0] d, input int h, input int ab,
                        input int g, output int t);
        int a;
        @(negedge OPB_CLK);
        t = cyc;
        OPB_SEL = 1'b1; OPB_RNW = rnw;
        OPB_ABUS = {BASE, 2'(ch), ad}; OPB_DBUS_IN = d;
        e_ld[t+1] = 1'b1; e_ad[t+1] = ad; e_di[t+1] = d;
        if (!CH_EN[ch]) begin
            a = t + 1;
            e_e[a] = 1'b1;
            repeat (a - t + 1 + h) @(negedge OPB_CLK);
            OPB_SEL = 1'b0;
        end else begin
            e_strb[t+1] = rnw ? 8'(1 << ch) : 8'(1 << (ch + 4));
            if (ab >= 0) begin
                repeat (1 + ab) @(negedge OPB_CLK);
                OPB_SEL = 1'b0;
            end else begin
                a = rnw ? t + 2 + RD_LAT : t + 2;
                e_x[a] = 1'b1;
                e_db[a] = rnw ? regval(ch, ad) : 32'd0;
                repeat (a - t + 1 + h) @(negedge OPB_CLK);
                OPB_SEL = 1'b0;
            end
        end
        repeat (g) drive_miss(6'd0, 1'b0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < MAXC; i++) begin
            e_strb[i] = 8'd0; e_x[i] = 1'b0; e_e[i] = 1'b0; e_db[i] = 32'd0;
            e_ld[i] = 1'b0; e_ad[i] = 16'd0; e_di[i] = 32'd0;
        end
        repeat (3) @(negedge OPB_CLK);
        OPB_RST = 1'b0;

        // Write to CAN3
        xfer(1'b0, 2, 16'h1234, 32'hDEADBEEF, 0, -1, 1, t);
        chk("t1_addr", {16'd0, CAN_ADDR}, 32'h0000_1234);
        chk("t1_di", CAN_DI, 32'hDEADBEEF);
        chk("t1_we_cycle", 32'(obs_s_cyc - t), 32'd1);
        chk("t1_ack_cycle", 32'(obs_x_cyc - t), 32'd2);
        $display("write ch2 addr=1234 ack at +%0d", obs_x_cyc - t);

        // Read from CAN1
        xfer(1'b1, 0, 16'h0010, 32'h0, 0, -1, 1, t);
        chk("t2_ack_cycle", 32'(obs_x_cyc - t), 32'd4);
        chk("t2_data", obs_db, 32'hA5B5_0010);
        $display("read ch0 addr=0010 data=%h ack at +%0d", obs_db, obs_x_cyc - t);

        // Access to the disabled channel 4
        xfer(1'b1, 3, 16'h0000, 32'h0, 0, -1, 1, t);
        chk("t3_err_cycle", 32'(obs_e_cyc - t), 32'd1);
        $display("disabled ch3 errack at +%0d", obs_e_cyc - t);

        // Wrong base with select held for 20 cycles
        repeat (20) drive_miss(6'h02, 1'b1);
        @(negedge OPB_CLK); OPB_SEL = 1'b0;
        $display("miss burst of 20 cycles");

        // Select held for 10 cycles after the ack
        xfer(1'b0, 1, 16'h0BEE, 32'h1111_2222, 10, -1, 0, t);
        xfer(1'b1, 1, 16'h0BEE, 32'h0, 0, -1, 0, t);
        $display("held select write then read ch1");

        // Read aborted in WAIT, then a normal read
        xfer(1'b1, 1, 16'h4444, 32'h0, 0, 1, 0, t);
        xfer(1'b1, 2, 16'h5555, 32'h0, 0, -1, 1, t);
        chk("t6_data", obs_db, 32'hF0F0_5557);
        $display("abort then read ch2 data=%h", obs_db);

        // Reset pulsed in WAIT
        @(negedge OPB_CLK);
        t = cyc;
        OPB_SEL = 1'b1; OPB_RNW = 1'b1; OPB_ABUS = {BASE, 2'd1, 16'h00AA};
        e_ld[t+1] = 1'b1; e_ad[t+1] = 16'h00AA; e_di[t+1] = OPB_DBUS_IN;
        e_strb[t+1] = 8'h02;
        repeat (2) @(negedge OPB_CLK);
        #3 OPB_RST = 1'b1;
        #1;
        chk("rst_ctrl", {22'd0, we_all, re_all, OPB_XFERACK, OPB_ERRACK}, 32'd0);
        chk("rst_dbus", OPB_DBUS_OUT, 32'd0);
        chk("rst_addr", {16'd0, CAN_ADDR}, 32'd0);
        chk("rst_di", CAN_DI, 32'd0);
        @(negedge OPB_CLK);
        OPB_RST = 1'b0; OPB_SEL = 1'b0;
        xfer(1'b0, 0, 16'h7777, 32'hCAFE_F00D, 0, -1, 0, t);
        $display("reset in WAIT then write ch0");

        // Randomized transfers
        for (int i = 0; i < 200; i++) begin
            logic rnw;
            int   ch, ab;
            rnw = 1'($urandom_range(0, 1));
            ch  = int'($urandom_range(0, 3));
            ab  = -1;
            if ($urandom_range(0, 5) == 0) ab = rnw ? int'($urandom_range(0, RD_LAT)) : 0;
            xfer(rnw, ch, 16'($urandom), $urandom, int'($urandom_range(0, 3)), ab,
                 int'($urandom_range(0, 2)), t);
            $display("xfer %0d rnw=%0d ch=%0d abort=%0d start=%0d", i, rnw, ch, ab, t);
        end

        repeat (4) @(negedge OPB_CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
